scan_chain_target: RTL and testbench
====================================

// Module: scan_chain_target
// PURPOSE
// FPGA-side model of the on-chip scan chain: the responder to ScanChain's master. Oversamples the
// master's sc_clk/sc_data on clki, shifts CHAIN_LEN bits in, drives s_chipout back, and latches a
// parallel config word at frame end. Used for loopback of ScanChain/okHost paths without silicon.
// PARAMETERS
// CHAIN_LEN    100   scan chain length in bits (matches ScanChain sc_out width)
// SYNC_STAGES  2     flip-flop stages on sc_clk_in/sc_data_in (min 2)
// IDLE_TIMEOUT 4096  clki cycles with no sc_clk edge that end a frame
// PORTS
// clki         in   1          system clock (100 MHz sys_clk)
// reset_n      in   1          synchronous, active-low reset
// sc_clk_in    in   1          master scan clock, async to clki
// sc_data_in   in   1          master scan data, async to clki
// capture_in   in   CHAIN_LEN  status word shifted back to master, MSB first
// s_chipout    out  1          serial data to master
// cfg_q        out  CHAIN_LEN  last complete frame received
// frame_done   out  1          1-cycle pulse at frame end
// frame_ok     out  1          last frame had exactly CHAIN_LEN bits (held to next frame_done)
// bit_count    out  $clog2(CHAIN_LEN+1)  rising edges in current frame, saturating
// overflow     out  1          current/last frame exceeded CHAIN_LEN edges (sticky to next frame)
// BEHAVIOUR
// - One clock; reset is synchronous and active-low (reset_n sampled on posedge clki).
// - Reset values: s_chipout=0, cfg_q=0, frame_done=0, frame_ok=0, bit_count=0, overflow=0, FSM=IDLE.
// - Sync: SYNC_STAGES FFs on both inputs, plus one history FF on sc_clk; rise = s & ~s_d, fall = ~s & s_d.
//   Data sampled from the synchronised data path at rise (same stage depth as clk path).
// - Latency: sc_clk rise -> shift register update = SYNC_STAGES+1 clki; fall -> s_chipout = SYNC_STAGES+1.
// - Master constraint: sc_clk high and low each >= SYNC_STAGES+2 clki cycles; faster is unsupported.
// - Shift: shreg <= {shreg[CHAIN_LEN-2:0], data_sync}; s_chipout tracks shreg[CHAIN_LEN-1].
// - FSM states IDLE, SHIFT, UPDATE:
//   IDLE:   shreg <= capture_in every cycle; s_chipout <= capture_in[CHAIN_LEN-1];
//           on rise: shift, bit_count=1, overflow=0, timer=0 -> SHIFT.
//   SHIFT:  rise: shift, bit_count+1 (saturates at CHAIN_LEN; edge CHAIN_LEN+1 sets overflow);
//           fall: s_chipout <= shreg[CHAIN_LEN-1]; any edge clears timer, else timer+1;
//           timer == IDLE_TIMEOUT-1 -> UPDATE.
//   UPDATE: frame_done=1; if bit_count==CHAIN_LEN && !overflow: cfg_q <= shreg, frame_ok=1;
//           else cfg_q unchanged, frame_ok=0. -> IDLE (bit_count held until next frame start).
// - Rise and fall never coincide after sync; a rise arriving in UPDATE is dropped, flagged by
//   frame_ok=0 on the following frame (bit count short).
// - Reset mid-frame: all state to reset values, partial frame discarded, cfg_q=0.
// - Overflow frames keep shifting (last CHAIN_LEN bits retained) but never update cfg_q.
// STRUCTURE
// - Shared package: FSM state enum (IDLE/SHIFT/UPDATE), default CHAIN_LEN, IDLE_TIMEOUT.
// - One sub-module: sc_edge_sync (SYNC_STAGES sync of clk+data, outputs rise, fall, data_sync).
// - Top: FSM, shift register, saturating bit counter, timeout counter, output regs.
// TESTING
// - Reset: reset_n=0 for 5 clki with sc_clk toggling -> all outputs 0, no frame_done.
// - Nominal: capture_in=100'hA5..A5, master shifts 100 bits of 100'h0123456789ABCDEF0123456789,
//   half-period 10 clki -> frame_done once, frame_ok=1, cfg_q=written word, s_chipout stream=A5..A5.
// - Short frame: 99 edges then idle -> frame_done after IDLE_TIMEOUT, frame_ok=0, cfg_q unchanged.
// - Long frame: 101 edges -> overflow=1, bit_count=100, frame_ok=0, cfg_q unchanged.
// - Reset mid-frame at edge 50, then full 100-bit frame -> cfg_q equals second frame only, frame_ok=1.
// - Loopback with ScanChain master: sc_out == capture_in and cfg_q == data_in for 3 random words.

Source files
------------

// File: rtl/scan_chain_target_pkg.sv
// Shared definitions for the scan chain target: FSM states and default sizing.
package scan_chain_target_pkg;

    localparam int unsigned DefaultChainLen    = 100;
    localparam int unsigned DefaultSyncStages  = 2;
    localparam int unsigned DefaultIdleTimeout = 4096;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StUpdate
    } sc_state_e;

endpackage

// File: rtl/scan_chain_target_sc_edge_sync.sv
// Synchronises the master's scan clock and data into the clki domain and
// reports single-cycle rise/fall strobes of the synchronised scan clock.
module scan_chain_target_sc_edge_sync
    import scan_chain_target_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = DefaultSyncStages  // must be >= 2
) (
    input  logic clki,
    input  logic sc_clk_in,
    input  logic sc_data_in,
    output logic rise,
    output logic fall,
    output logic data_sync
);

    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] data_sync_q;
    logic                   clk_hist_q;

    // Plain synchronisers with no reset: they only track the pins, so a reset
    // release can never manufacture an edge that the master did not produce.
    always_ff @(posedge clki) begin
        clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], sc_clk_in};
        data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], sc_data_in};
        clk_hist_q  <= clk_sync_q[SYNC_STAGES-1];
    end

    assign rise      = clk_sync_q[SYNC_STAGES-1] & ~clk_hist_q;
    assign fall      = ~clk_sync_q[SYNC_STAGES-1] & clk_hist_q;
    // Same stage depth as the clock path, so data is stable when rise fires.
    assign data_sync = data_sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/scan_chain_target.sv
// FPGA-side responder for the scan chain master: shifts CHAIN_LEN bits in,
// streams the capture word back MSB first, and latches the config word at
// the end of each well-formed frame.
module scan_chain_target
    import scan_chain_target_pkg::*;
#(
    parameter int unsigned CHAIN_LEN    = DefaultChainLen,
    parameter int unsigned SYNC_STAGES  = DefaultSyncStages,
    parameter int unsigned IDLE_TIMEOUT = DefaultIdleTimeout
) (
    input  logic                             clki,
    input  logic                             reset_n,
    input  logic                             sc_clk_in,
    input  logic                             sc_data_in,
    input  logic [CHAIN_LEN-1:0]             capture_in,
    output logic                             s_chipout,
    output logic [CHAIN_LEN-1:0]             cfg_q,
    output logic                             frame_done,
    output logic                             frame_ok,
    output logic [$clog2(CHAIN_LEN+1)-1:0]   bit_count,
    output logic                             overflow
);

    localparam int unsigned CntW = $clog2(CHAIN_LEN + 1);
    localparam int unsigned TmrW = $clog2(IDLE_TIMEOUT);
    localparam logic [CntW-1:0] CntFull = CntW'(CHAIN_LEN);
    localparam logic [TmrW-1:0] TmrLast = TmrW'(IDLE_TIMEOUT - 1);

    logic rise;
    logic fall;
    logic data_sync;

    sc_state_e              state_q, state_d;
    logic [CHAIN_LEN-1:0]   shreg_q, shreg_d;
    logic [CHAIN_LEN-1:0]   cfg_d;
    logic                   chipout_q, chipout_d;
    logic                   frame_done_q, frame_done_d;
    logic                   frame_ok_q, frame_ok_d;
    logic [CntW-1:0]        bit_count_q, bit_count_d;
    logic                   overflow_q, overflow_d;
    logic [TmrW-1:0]        timer_q, timer_d;

    scan_chain_target_sc_edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_edge_sync (
        .clki      (clki),
        .sc_clk_in (sc_clk_in),
        .sc_data_in(sc_data_in),
        .rise      (rise),
        .fall      (fall),
        .data_sync (data_sync)
    );

    // Frame FSM plus next-state for shift register, counters and outputs.
    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        cfg_d        = cfg_q;
        chipout_d    = chipout_q;
        frame_done_d = 1'b0;
        frame_ok_d   = frame_ok_q;
        bit_count_d  = bit_count_q;
        overflow_d   = overflow_q;
        timer_d      = timer_q;

        unique case (state_q)
            StIdle: begin
                // Keep the capture word parked so the first bit is ready
                // before the master's first rising edge.
                shreg_d   = capture_in;
                chipout_d = capture_in[CHAIN_LEN-1];
                if (rise) begin
                    shreg_d     = {shreg_q[CHAIN_LEN-2:0], data_sync};
                    bit_count_d = CntW'(1);
                    overflow_d  = 1'b0;
                    timer_d     = '0;
                    state_d     = StShift;
                end
            end

            StShift: begin
                if (rise) begin
                    shreg_d = {shreg_q[CHAIN_LEN-2:0], data_sync};
                    if (bit_count_q == CntFull) begin
                        overflow_d = 1'b1;
                    end else begin
                        bit_count_d = bit_count_q + 1'b1;
                    end
                end
                if (fall) begin
                    chipout_d = shreg_q[CHAIN_LEN-1];
                end
                if (rise || fall) begin
                    timer_d = '0;
                end else if (timer_q == TmrLast) begin
                    state_d = StUpdate;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            StUpdate: begin
                // Rises landing here are dropped; the next frame comes up short.
                frame_done_d = 1'b1;
                if ((bit_count_q == CntFull) && !overflow_q) begin
                    cfg_d      = shreg_q;
                    frame_ok_d = 1'b1;
                end else begin
                    frame_ok_d = 1'b0;
                end
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clki) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            shreg_q      <= '0;
            cfg_q        <= '0;
            chipout_q    <= 1'b0;
            frame_done_q <= 1'b0;
            frame_ok_q   <= 1'b0;
            bit_count_q  <= '0;
            overflow_q   <= 1'b0;
            timer_q      <= '0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            cfg_q        <= cfg_d;
            chipout_q    <= chipout_d;
            frame_done_q <= frame_done_d;
            frame_ok_q   <= frame_ok_d;
            bit_count_q  <= bit_count_d;
            overflow_q   <= overflow_d;
            timer_q      <= timer_d;
        end
    end

    assign s_chipout  = chipout_q;
    assign frame_done = frame_done_q;
    assign frame_ok   = frame_ok_q;
    assign bit_count  = bit_count_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_scan_chain_target.sv
// Self-checking bench for scan_chain_target: table of directed frames,
// hand-written reset sequences, and random loopback frames checked against
// a delay-line / frame-length model.
`timescale 1ns/1ps
module tb_scan_chain_target;

    localparam int CL   = 100;
    localparam int SS   = 2;
    localparam int IDLE = 512;

    logic          clki;
    logic          reset_n;
    logic          sc_clk_in;
    logic          sc_data_in;
    logic [CL-1:0] capture_in;
    logic          s_chipout;
    logic [CL-1:0] cfg_q;
    logic          frame_done;
    logic          frame_ok;
    logic [6:0]    bit_count;
    logic          overflow;

    int n_vec;
    int n_err;
    int done_cnt;
    logic [CL-1:0] cfg_model;

    scan_chain_target #(
        .CHAIN_LEN   (CL),
        .SYNC_STAGES (SS),
        .IDLE_TIMEOUT(IDLE)
    ) dut (
        .clki      (clki),
        .reset_n   (reset_n),
        .sc_clk_in (sc_clk_in),
        .sc_data_in(sc_data_in),
        .capture_in(capture_in),
        .s_chipout (s_chipout),
        .cfg_q     (cfg_q),
        .frame_done(frame_done),
        .frame_ok  (frame_ok),
        .bit_count (bit_count),
        .overflow  (overflow)
    );

    initial clki = 1'b0;
    always #5 clki = ~clki;

    initial done_cnt = 0;
    always @(negedge clki) begin
        if (frame_done) done_cnt <= done_cnt + 1;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        string         name;
        int            nbits;
        logic [CL-1:0] word;
        logic [CL-1:0] cap;
        int            half;
        logic          e_ok;
        int            e_cnt;
        logic          e_ovf;
        logic [CL-1:0] e_cfg;
    } vec_t;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clki);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Master side: MSB-first bits of word, s_chipout sampled just before each rise.
    task automatic master_frame(input int nbits, input logic [127:0] word, input int half,
                                input int abort_at, output logic [127:0] got);
        got = '0;
        for (int i = 0; i < nbits; i++) begin
            sc_data_in = word[nbits-1-i];
            sc_clk_in  = 1'b0;
            tick(half);
            got[i]    = s_chipout;
            sc_clk_in = 1'b1;
            if (i + 1 == abort_at) begin
                tick(half / 2);
                reset_n = 1'b0;
                return;
            end
            tick(half);
        end
        sc_clk_in = 1'b0;
        tick(half);
    endtask

    // The target behaves as a CL-bit delay line: capture word first, then echoes.
    function automatic logic [127:0] exp_stream(input int nbits, input logic [127:0] word,
                                                input logic [CL-1:0] cap);
        logic [127:0] e;
        e = '0;
        for (int i = 0; i < nbits; i++) begin
            if (i < CL) e[i] = cap[CL-1-i];
            else        e[i] = word[nbits-1-(i-CL)];
        end
        return e;
    endfunction

    task automatic run_frame(input string name, input int nbits, input logic [CL-1:0] word,
                             input logic [CL-1:0] cap, input int half, input logic e_ok,
                             input int e_cnt, input logic e_ovf, input logic [CL-1:0] e_cfg);
        logic [127:0] got;
        logic [127:0] w;
        int d0;
        int waited;
        w          = {28'b0, word};
        capture_in = cap;
        tick(4);
        d0 = done_cnt;
        master_frame(nbits, w, half, 0, got);
        check({name, ":chipout"}, got, exp_stream(nbits, w, cap));
        waited = 0;
        while (done_cnt == d0 && waited < IDLE + 100) begin
            tick(1);
            waited++;
        end
        tick(5);
        check({name, ":done_pulses"}, 128'(done_cnt - d0), 128'(1));
        check({name, ":frame_ok"}, 128'(frame_ok), 128'(e_ok));
        check({name, ":bit_count"}, 128'(bit_count), 128'(e_cnt));
        check({name, ":overflow"}, 128'(overflow), 128'(e_ovf));
        check({name, ":cfg_q"}, 128'(cfg_q), 128'(e_cfg));
        cfg_model = e_cfg;
    endtask

    initial begin
        vec_t          tbl[4];
        logic [CL-1:0] w0, w3, w4, w5, cap_a5, cap_5a;
        logic [127:0]  got;
        logic [127:0]  r;
        int            d0;

        n_vec      = 0;
        n_err      = 0;
        cfg_model  = '0;
        w0         = 100'h123456789ABCDEF0123456789;
        w3         = 100'hFEDCBA9876543210FEDCBA987;
        w4         = 100'hFFFFFFFFFFFFFFFFFFFFFFFFF;
        w5         = 100'h0F0F0F0F0F0F0F0F0F0F0F0F0;
        cap_a5     = 100'hA5A5A5A5A5A5A5A5A5A5A5A5A;
        cap_5a     = 100'h5A5A5A5A5A5A5A5A5A5A5A5A5;

        tbl[0] = '{"nominal", 100, w0, cap_a5, 10, 1'b1, 100, 1'b0, w0};
        tbl[1] = '{"short99", 99, w3, cap_a5, 10, 1'b0, 99, 1'b0, w0};
        tbl[2] = '{"long101", 101, w3, cap_5a, 10, 1'b0, 100, 1'b1, w0};
        tbl[3] = '{"nominal2", 100, w3, cap_5a, 6, 1'b1, 100, 1'b0, w3};

        // Reset with the scan clock toggling: nothing may leak through.
        reset_n    = 1'b0;
        sc_clk_in  = 1'b0;
        sc_data_in = 1'b1;
        capture_in = '0;
        tick(1);
        for (int i = 0; i < 5; i++) begin
            sc_clk_in = ~sc_clk_in;
            tick(1);
        end
        sc_clk_in = 1'b0;
        tick(4);
        check("rst:s_chipout", 128'(s_chipout), 128'(0));
        check("rst:cfg_q", 128'(cfg_q), 128'(0));
        check("rst:frame_ok", 128'(frame_ok), 128'(0));
        check("rst:bit_count", 128'(bit_count), 128'(0));
        check("rst:overflow", 128'(overflow), 128'(0));
        reset_n = 1'b1;
        tick(20);
        check("rst:no_frame_done", 128'(done_cnt), 128'(0));
        check("rst:idle_bit_count", 128'(bit_count), 128'(0));

        for (int k = 0; k < 4; k++) begin
            run_frame(tbl[k].name, tbl[k].nbits, tbl[k].word, tbl[k].cap, tbl[k].half,
                      tbl[k].e_ok, tbl[k].e_cnt, tbl[k].e_ovf, tbl[k].e_cfg);
        end

        // Reset during bit 50 of a frame; the partial frame must vanish.
        capture_in = cap_a5;
        tick(4);
        master_frame(100, {28'b0, w4}, 10, 50, got);
        sc_clk_in = 1'b0;
        tick(5);
        check("midrst:cfg_q", 128'(cfg_q), 128'(0));
        check("midrst:bit_count", 128'(bit_count), 128'(0));
        check("midrst:frame_ok", 128'(frame_ok), 128'(0));
        d0 = done_cnt;
        reset_n = 1'b1;
        cfg_model = '0;
        tick(IDLE + 20);
        check("midrst:no_frame_done", 128'(done_cnt), 128'(d0));
        run_frame("after_rst", 100, w5, cap_a5, 10, 1'b1, 100, 1'b0, w5);

        // Random loopback frames, then random-length frames around CL.
        for (int k = 0; k < 6; k++) begin
            int            n;
            int            half;
            logic [CL-1:0] w;
            logic [CL-1:0] c;
            logic          ok;
            n    = (k < 3) ? CL : int'($urandom_range(CL + 2, CL - 2));
            half = int'($urandom_range(12, SS + 2));
            r    = {$urandom(), $urandom(), $urandom(), $urandom()};
            w    = r[CL-1:0];
            r    = {$urandom(), $urandom(), $urandom(), $urandom()};
            c    = r[CL-1:0];
            ok   = (n == CL);
            run_frame("random", n, w, c, half, ok, (n > CL) ? CL : n, (n > CL),
                      ok ? w : cfg_model);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
